// File: rtl/melbank_pkg.sv
// Shared definitions for the mel filterbank engine: ROM word layout,
// Q1.15 constants and FSM state encoding.
package melbank_pkg;

  localparam int unsigned Q15_ONE   = 32768;
  localparam int unsigned Q15_SHIFT = 15;
  localparam int unsigned WGT_W     = 16;
  localparam int unsigned COMP_W    = 17;
  localparam int unsigned IDX_W     = 8;
  localparam int unsigned STATE_W   = 2;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  // Coefficient ROM word: [31] en, [30:24] reserved, [23:16] filt_idx, [15:0] weight
  typedef struct packed {
    logic             en;
    logic [6:0]       rsvd;
    logic [IDX_W-1:0] filt_idx;
    logic [WGT_W-1:0] weight;
  } rom_word_t;

  // 1.0 - w in Q1.15; weights above 1.0 leave nothing for the lower filter
  function automatic logic [COMP_W-1:0] q15_complement(input logic [WGT_W-1:0] w);
    if ({1'b0, w} >= COMP_W'(Q15_ONE)) return '0;
    return COMP_W'(Q15_ONE) - {1'b0, w};
  endfunction

endpackage

// File: rtl/mel_sat_acc.sv
// Bank of N_FILT saturating accumulators with two independent add ports,
// a synchronous clear and a combinational read port.
module mel_sat_acc #(
  parameter int unsigned N_FILT     = 40,
  parameter int unsigned ACC_WIDTH  = 48,
  parameter int unsigned TERM_WIDTH = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  a_en,
  input  logic [7:0]            a_idx,
  input  logic [TERM_WIDTH-1:0] a_val,
  input  logic                  b_en,
  input  logic [7:0]            b_idx,
  input  logic [TERM_WIDTH-1:0] b_val,
  input  logic [7:0]            rd_idx,
  output logic [ACC_WIDTH-1:0]  rd_data_c
);

  localparam int unsigned SUM_W = ACC_WIDTH + 2;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

  logic [ACC_WIDTH-1:0] acc_q [N_FILT];
  logic [ACC_WIDTH-1:0] acc_d [N_FILT];

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0]  acc,
                                                   input logic [TERM_WIDTH-1:0] x,
                                                   input logic [TERM_WIDTH-1:0] y);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(x) + SUM_W'(y);
    return (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : sum[ACC_WIDTH-1:0];
  endfunction

  // The two ports address different entries in practice; both are summed regardless
  always_comb begin
    for (int i = 0; i < int'(N_FILT); i++) begin
      acc_d[i] = sat_add(acc_q[i],
                         (a_en && a_idx == 8'(i)) ? a_val : '0,
                         (b_en && b_idx == 8'(i)) ? b_val : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_FILT); i++) acc_q[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(N_FILT); i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_FILT); i++) acc_q[i] <= acc_d[i];
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int i = 0; i < int'(N_FILT); i++) begin
      if (rd_idx == 8'(i)) rd_data_c = acc_q[i];
    end
  end

endmodule

// File: rtl/mel_filter_engine.sv
// Mel filterbank engine: streams power bins against an external coefficient
// ROM, accumulates triangular-filter energies, then emits one value per filter.
module mel_filter_engine
  import melbank_pkg::*;
#(
  parameter int unsigned N_BIN       = 256,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned N_FILT      = 40,
  parameter int unsigned ROM_LATENCY = 1,
  parameter int unsigned PWR_WIDTH   = 32,
  parameter int unsigned ACC_WIDTH   = 48
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pwr_valid,
  output logic                  pwr_ready,
  input  logic [PWR_WIDTH-1:0]  pwr_data,
  input  logic                  pwr_last,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [31:0]           rom_rd_data,
  output logic                  mel_valid,
  input  logic                  mel_ready,
  output logic [ACC_WIDTH-1:0]  mel_data,
  output logic [7:0]            mel_idx,
  output logic                  mel_last,
  output logic                  frame_err
);

  localparam int unsigned TERM_W = PWR_WIDTH + 1;
  localparam int unsigned PROD_W = PWR_WIDTH + COMP_W;
  localparam logic [ADDR_WIDTH-1:0] B_MAX = ADDR_WIDTH'(N_BIN - 1);
  localparam logic [7:0] IDX_MAX = 8'(N_FILT - 1);
  localparam logic [7:0] FILT_N  = 8'(N_FILT);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] b_q, b_d;
  logic                  pwr_hs, b_at_max, frame_end, frame_err_d;

  logic [ROM_LATENCY-1:0] dl_vld_q;
  logic [PWR_WIDTH-1:0]   dl_dat_q [ROM_LATENCY];
  logic                   al_vld;
  logic [PWR_WIDTH-1:0]   al_dat;
  rom_word_t              rom_w;
  logic                   unused_rsvd;

  logic [PROD_W-1:0] prod_up, prod_lo;
  logic              mul_vld_q, up_en_q, lo_en_q;
  logic [7:0]        up_idx_q, lo_idx_q;
  logic [TERM_W-1:0] up_term_q, lo_term_q;
  logic              pipe_empty;

  logic                 mel_hs, acc_clr;
  logic [7:0]           rd_idx;
  logic [ACC_WIDTH-1:0] rd_data_c;
  logic                 mel_valid_d, mel_last_d;
  logic [ACC_WIDTH-1:0] mel_data_d;
  logic [7:0]           mel_idx_d;

  assign pwr_ready = (state_q == ST_ACCUM);
  assign rom_addr  = b_q;
  assign pwr_hs    = pwr_valid & pwr_ready;
  assign b_at_max  = (b_q == B_MAX);
  assign frame_end = pwr_last | b_at_max;
  assign frame_err_d = pwr_hs & (pwr_last ^ b_at_max);
  assign b_d = !pwr_hs ? b_q : (frame_end ? '0 : b_q + ADDR_WIDTH'(1));

  // Power samples ride alongside the ROM read so both arrive together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_vld_q <= '0;
      for (int i = 0; i < int'(ROM_LATENCY); i++) dl_dat_q[i] <= '0;
    end else begin
      dl_vld_q[0] <= pwr_hs;
      dl_dat_q[0] <= pwr_data;
      for (int i = 1; i < int'(ROM_LATENCY); i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
        dl_dat_q[i] <= dl_dat_q[i-1];
      end
    end
  end

  assign al_vld      = dl_vld_q[ROM_LATENCY-1];
  assign al_dat      = dl_dat_q[ROM_LATENCY-1];
  assign rom_w       = rom_word_t'(rom_rd_data);
  assign unused_rsvd = ^rom_w.rsvd;

  assign prod_up = PROD_W'(al_dat) * PROD_W'(rom_w.weight);
  assign prod_lo = PROD_W'(al_dat) * PROD_W'(q15_complement(rom_w.weight));

  // Split each bin between its own filter and the one below; out-of-bank targets are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_vld_q <= 1'b0;
      up_en_q   <= 1'b0;
      lo_en_q   <= 1'b0;
      up_idx_q  <= '0;
      lo_idx_q  <= '0;
      up_term_q <= '0;
      lo_term_q <= '0;
    end else begin
      mul_vld_q <= al_vld;
      up_en_q   <= al_vld & rom_w.en & (rom_w.filt_idx < FILT_N);
      lo_en_q   <= al_vld & rom_w.en & (rom_w.filt_idx != 8'd0) & (rom_w.filt_idx <= FILT_N);
      up_idx_q  <= rom_w.filt_idx;
      lo_idx_q  <= rom_w.filt_idx - 8'd1;
      up_term_q <= TERM_W'(prod_up >> Q15_SHIFT);
      lo_term_q <= TERM_W'(prod_lo >> Q15_SHIFT);
    end
  end

  assign pipe_empty = ~(|dl_vld_q) & ~mul_vld_q;

  mel_sat_acc #(
    .N_FILT     (N_FILT),
    .ACC_WIDTH  (ACC_WIDTH),
    .TERM_WIDTH (TERM_W)
  ) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (acc_clr),
    .a_en      (up_en_q),
    .a_idx     (up_idx_q),
    .a_val     (up_term_q),
    .b_en      (lo_en_q),
    .b_idx     (lo_idx_q),
    .b_val     (lo_term_q),
    .rd_idx    (rd_idx),
    .rd_data_c (rd_data_c)
  );

  assign mel_hs = mel_valid & mel_ready;
  assign rd_idx = (state_q == ST_OUTPUT && mel_hs && !mel_last) ? mel_idx + 8'd1 : mel_idx;

  always_comb begin
    state_d     = state_q;
    acc_clr     = 1'b0;
    mel_valid_d = mel_valid;
    mel_data_d  = mel_data;
    mel_idx_d   = mel_idx;
    mel_last_d  = mel_last;
    case (state_q)
      ST_ACCUM: begin
        if (pwr_hs && frame_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_empty) state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (!mel_valid) begin
          mel_valid_d = 1'b1;
          mel_data_d  = rd_data_c;
          mel_last_d  = (mel_idx == IDX_MAX);
        end else if (mel_hs) begin
          if (mel_last) begin
            state_d     = ST_ACCUM;
            acc_clr     = 1'b1;
            mel_valid_d = 1'b0;
            mel_data_d  = '0;
            mel_idx_d   = '0;
            mel_last_d  = 1'b0;
          end else begin
            mel_idx_d  = rd_idx;
            mel_data_d = rd_data_c;
            mel_last_d = (rd_idx == IDX_MAX);
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      b_q       <= '0;
      mel_valid <= 1'b0;
      mel_data  <= '0;
      mel_idx   <= '0;
      mel_last  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      b_q       <= b_d;
      mel_valid <= mel_valid_d;
      mel_data  <= mel_data_d;
      mel_idx   <= mel_idx_d;
      mel_last  <= mel_last_d;
      frame_err <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_mel_filter_engine.sv
// Directed bench for mel_filter_engine: default instance (ROM latency 1) and a
// ROM-latency-2 / 40-bit / 512-bin instance, each fed by a modelled coefficient ROM.
module tb_mel_filter_engine;

  localparam int NF = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, pwr_valid, pwr_last, mel_ready, sel;
  logic [31:0] pwr_data;
  int          rom_mode;

  logic        pwr_valid_a, pwr_ready_a, mel_valid_a, mel_last_a, frame_err_a;
  logic [7:0]  rom_addr_a, mel_idx_a;
  logic [31:0] rom_a_q;
  logic [47:0] mel_data_a;

  logic        pwr_valid_b, pwr_ready_b, mel_valid_b, mel_last_b, frame_err_b;
  logic [8:0]  rom_addr_b;
  logic [7:0]  mel_idx_b;
  logic [31:0] rom_b_q1, rom_b_q2;
  logic [39:0] mel_data_b;

  logic        pwr_ready_m, mel_valid_m, mel_last_m, frame_err_m;
  logic [8:0]  rom_addr_m;
  logic [7:0]  mel_idx_m;
  logic [47:0] mel_data_m;

  assign pwr_valid_a = pwr_valid & ~sel;
  assign pwr_valid_b = pwr_valid & sel;
  assign pwr_ready_m = sel ? pwr_ready_b : pwr_ready_a;
  assign mel_valid_m = sel ? mel_valid_b : mel_valid_a;
  assign mel_last_m  = sel ? mel_last_b : mel_last_a;
  assign frame_err_m = sel ? frame_err_b : frame_err_a;
  assign rom_addr_m  = sel ? rom_addr_b : {1'b0, rom_addr_a};
  assign mel_idx_m   = sel ? mel_idx_b : mel_idx_a;
  assign mel_data_m  = sel ? 48'(mel_data_b) : mel_data_a;

  mel_filter_engine u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .pwr_valid(pwr_valid_a), .pwr_ready(pwr_ready_a), .pwr_data(pwr_data), .pwr_last(pwr_last),
    .rom_addr(rom_addr_a), .rom_rd_data(rom_a_q),
    .mel_valid(mel_valid_a), .mel_ready(mel_ready), .mel_data(mel_data_a),
    .mel_idx(mel_idx_a), .mel_last(mel_last_a), .frame_err(frame_err_a)
  );

  mel_filter_engine #(
    .N_BIN(512), .ADDR_WIDTH(9), .ROM_LATENCY(2), .ACC_WIDTH(40)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .pwr_valid(pwr_valid_b), .pwr_ready(pwr_ready_b), .pwr_data(pwr_data), .pwr_last(pwr_last),
    .rom_addr(rom_addr_b), .rom_rd_data(rom_b_q2),
    .mel_valid(mel_valid_b), .mel_ready(mel_ready), .mel_data(mel_data_b),
    .mel_idx(mel_idx_b), .mel_last(mel_last_b), .frame_err(frame_err_b)
  );

  // Coefficient tables: 0 uniform half-split to filter 1, 1 eight bins per filter,
  // 2 edge words, 3 full weight into filter 3
  function automatic logic [31:0] rom_word(input int mode, input int a);
    logic       en;
    logic [7:0] idx;
    logic [15:0] w;
    en = 1'b1; idx = 8'd0; w = 16'd0;
    case (mode)
      0: begin idx = 8'd1; w = 16'd16384; end
      1: begin idx = 8'(a / 8); w = 16'd32768; end
      2: begin
        w = 16'd16384;
        case (a)
          0: idx = 8'd0;
          1: idx = 8'd40;
          2: idx = 8'd200;
          default: begin en = 1'b0; idx = 8'd5; end
        endcase
      end
      default: begin idx = 8'd3; w = 16'd32768; end
    endcase
    return {en, 7'd0, idx, w};
  endfunction

  always @(posedge clk) begin
    rom_a_q  <= rom_word(rom_mode, int'(rom_addr_a));
    rom_b_q1 <= rom_word(rom_mode, int'(rom_addr_b));
    rom_b_q2 <= rom_b_q1;
  end

  int fe_cnt = 0;
  always @(negedge clk) if (frame_err_m) fe_cnt <= fe_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
  endtask

  logic [47:0] exp_d [NF];
  logic [47:0] got_d [NF];
  logic [7:0]  got_i [NF];
  logic        got_l [NF];

  task automatic clear_exp();
    for (int i = 0; i < NF; i++) exp_d[i] = '0;
  endtask

  task automatic send_frame(input int n, input int last_at, input logic [31:0] p);
    int g;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g = 0;
      while (!pwr_ready_m && g < 200) begin @(negedge clk); g++; end
      if (g >= 200) check("pwr_ready_timeout", 64'(pwr_ready_m), 64'd1);
      pwr_valid = 1'b1;
      pwr_data  = p;
      pwr_last  = (i == last_at);
      @(posedge clk);
    end
    #1;
    pwr_valid = 1'b0;
    pwr_last  = 1'b0;
  endtask

  task automatic first_valid_latency(input string tag, input int want);
    int k;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!mel_valid_m && k < 50);
    check(tag, 64'(k), 64'(want));
  endtask

  task automatic collect(input int n_take, input int stall_at);
    int got_n, guard, stalls;
    logic [47:0] hold_d;
    logic [7:0]  hold_i;
    got_n = 0; guard = 0; stalls = 0; hold_d = '0; hold_i = '0;
    while (got_n < n_take && guard < 3000) begin
      @(negedge clk);
      guard++;
      mel_ready = 1'b0;
      if (mel_valid_m) begin
        if (int'(mel_idx_m) == stall_at && stalls < 5) begin
          if (stalls == 0) begin
            hold_d = mel_data_m;
            hold_i = mel_idx_m;
            check("busy_in_output", 64'(pwr_ready_m), 64'd0);
          end else begin
            check("stall_data", 64'(mel_data_m), 64'(hold_d));
            check("stall_idx", 64'(mel_idx_m), 64'(hold_i));
          end
          stalls++;
        end else begin
          if (int'(mel_idx_m) == stall_at) check("stall_release", 64'(mel_data_m), 64'(hold_d));
          got_d[got_n] = mel_data_m;
          got_i[got_n] = mel_idx_m;
          got_l[got_n] = mel_last_m;
          got_n++;
          mel_ready = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1 mel_ready = 1'b0;
    check("collect_count", 64'(got_n), 64'(n_take));
  endtask

  task automatic verify(input string tag);
    for (int i = 0; i < NF; i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(got_d[i]), 64'(exp_d[i]));
      check($sformatf("%s_idx%0d", tag, i), 64'(got_i[i]), 64'(i));
      check($sformatf("%s_last%0d", tag, i), 64'(got_l[i]), 64'(i == NF - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int fe_base;
    rst_n = 1'b0; pwr_valid = 1'b0; pwr_last = 1'b0; pwr_data = '0;
    mel_ready = 1'b0; sel = 1'b0; rom_mode = 0;
    repeat (3) @(negedge clk);
    check("rst_mel_valid", 64'(mel_valid_m), 64'd0);
    check("rst_mel_last", 64'(mel_last_m), 64'd0);
    check("rst_frame_err", 64'(frame_err_m), 64'd0);
    check("rst_mel_data", 64'(mel_data_m), 64'd0);
    check("rst_mel_idx", 64'(mel_idx_m), 64'd0);
    check("rst_rom_addr", 64'(rom_addr_m), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_pwr_ready", 64'(pwr_ready_m), 64'd1);

    // Short frame (pwr_last at bin 99) with backpressure at filter 7
    rom_mode = 1;
    fe_base = fe_cnt;
    send_frame(100, 99, 32'd10);
    check("short_addr_restart", 64'(rom_addr_m), 64'd0);
    check("short_drain_busy", 64'(pwr_ready_m), 64'd0);
    first_valid_latency("short_latency", 4);
    collect(NF, 7);
    check("short_frame_err", 64'(fe_cnt - fe_base), 64'd1);
    clear_exp();
    for (int k = 0; k < 12; k++) exp_d[k] = 48'd80;
    exp_d[12] = 48'd40;
    verify("short");
    @(negedge clk);
    check("short_ready_back", 64'(pwr_ready_m), 64'd1);

    // Full frame, every bin split evenly between filters 1 and 0
    rom_mode = 0;
    fe_base = fe_cnt;
    send_frame(256, 255, 32'd1000);
    first_valid_latency("uniform_latency", 4);
    collect(NF, -1);
    check("uniform_frame_err", 64'(fe_cnt - fe_base), 64'd0);
    clear_exp();
    exp_d[0] = 48'd128000;
    exp_d[1] = 48'd128000;
    verify("uniform");

    // Reset during output, then a fresh frame must not carry old sums
    send_frame(256, 255, 32'd1000);
    collect(20, -1);
    @(negedge clk);
    check("pre_reset_idx", 64'(mel_idx_m), 64'd20);
    check("pre_reset_valid", 64'(mel_valid_m), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", 64'(mel_valid_m), 64'd0);
    check("mid_reset_data", 64'(mel_data_m), 64'd0);
    check("mid_reset_idx", 64'(mel_idx_m), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(pwr_ready_m), 64'd1);
    send_frame(256, 255, 32'd2000);
    first_valid_latency("fresh_latency", 4);
    collect(NF, -1);
    clear_exp();
    exp_d[0] = 48'd256000;
    exp_d[1] = 48'd256000;
    verify("fresh");

    // ROM latency 2 with out-of-range and disabled coefficient words
    sel = 1'b1;
    rom_mode = 2;
    @(negedge clk);
    fe_base = fe_cnt;
    send_frame(4, 3, 32'd1000);
    first_valid_latency("edge_latency", 5);
    collect(NF, -1);
    check("edge_frame_err", 64'(fe_cnt - fe_base), 64'd1);
    clear_exp();
    exp_d[0]  = 48'd500;
    exp_d[39] = 48'd500;
    verify("edge");

    // Full-scale power at unit weight saturates the 40-bit accumulator
    rom_mode = 3;
    fe_base = fe_cnt;
    send_frame(512, 511, 32'hFFFF_FFFF);
    first_valid_latency("sat_latency", 5);
    collect(NF, -1);
    check("sat_frame_err", 64'(fe_cnt - fe_base), 64'd0);
    clear_exp();
    exp_d[3] = 48'hFF_FFFF_FFFF;
    verify("sat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
